// File: rtl/int_rx_alu.sv
// int_rx_alu: receive-side command interpreter for the UART calculator.
// ASCII characters are buffered in a first-word-fall-through FIFO, parsed as
// "<digit A> <operator> <digit B> <CR>", then loaded into an ALU handler over
// a one-hot load bus.
//
// Ports:
//   CLK, RESET         clock, synchronous active-high reset
//   wr, w_data         FIFO write strobe and character
//   full, empty        FIFO status
//   RESULTADO          signed 8-bit ALU result (combinational from ALU regs)
//   data_out, SEL      load bus value and one-hot select (A / B / opcode)
//   RD_FIFO            FIFO pop from the parser
//   STATE              parser state code
//   CH                 last character popped
//   DATOA, DATOB, OP   decoded operands and opcode
module int_rx_alu #(
    parameter int unsigned B = 8,
    parameter int unsigned W = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic         full,
    output logic         empty,
    output logic [7:0]   RESULTADO,
    output logic [7:0]   data_out,
    output logic [2:0]   SEL,
    output logic         RD_FIFO,
    output logic [2:0]   STATE,
    output logic [7:0]   CH,
    output logic [7:0]   DATOA,
    output logic [7:0]   DATOB,
    output logic [7:0]   OP
);

    localparam int unsigned DEPTH = 2 ** W;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_ZERO = 8'h30;
    localparam logic [7:0] CHAR_NINE = 8'h39;

    localparam logic [7:0] OPC_ADD = 8'h20;
    localparam logic [7:0] OPC_SUB = 8'h22;
    localparam logic [7:0] OPC_AND = 8'h24;
    localparam logic [7:0] OPC_OR  = 8'h25;
    localparam logic [7:0] OPC_XOR = 8'h26;
    localparam logic [7:0] OPC_NOR = 8'h27;
    localparam logic [7:0] OPC_SRA = 8'h03;
    localparam logic [7:0] OPC_SRL = 8'h02;

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_OP  = 3'd1,
        GET_B   = 3'd2,
        GET_END = 3'd3,
        LOAD_A  = 3'd4,
        LOAD_B  = 3'd5,
        LOAD_OP = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [B-1:0] mem [DEPTH];
    logic [W-1:0] wr_ptr;
    logic [W-1:0] rd_ptr;
    logic         do_wr;
    logic         do_rd;
    logic [7:0]   ch_in;

    // A pop only happens when there is data; a write into a full FIFO is
    // allowed only when the same cycle frees a slot.
    assign do_rd = RD_FIFO && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign ch_in = 8'(mem[rd_ptr]);

    // Storage array, no reset needed: pointers define validity.
    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr] <= w_data;
        end
    end

    // Pointer and status flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + W'(1);
            end
            if (do_wr && !do_rd) begin
                empty <= 1'b0;
                full  <= ((wr_ptr + W'(1)) == rd_ptr);
            end else if (do_rd && !do_wr) begin
                full  <= 1'b0;
                empty <= ((rd_ptr + W'(1)) == wr_ptr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Character decode
    // ------------------------------------------------------------------
    logic       is_digit;
    logic       op_valid;
    logic [7:0] op_code;

    assign is_digit = (ch_in >= CHAR_ZERO) && (ch_in <= CHAR_NINE);

    // ASCII operator to ALU opcode.
    always_comb begin
        op_valid = 1'b1;
        op_code  = 8'h00;
        case (ch_in)
            8'h2B:   op_code = OPC_ADD;  // '+'
            8'h2D:   op_code = OPC_SUB;  // '-'
            8'h26:   op_code = OPC_AND;  // '&'
            8'h7C:   op_code = OPC_OR;   // '|'
            8'h5E:   op_code = OPC_XOR;  // '^'
            8'h7E:   op_code = OPC_NOR;  // '~'
            8'h3E:   op_code = OPC_SRA;  // '>'
            8'h7D:   op_code = OPC_SRL;  // '}'
            default: op_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Parser FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t state_nxt;

    assign STATE = state;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= GET_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; GET states only advance on a pop, invalid characters
    // restart the expression.
    always_comb begin
        state_nxt = state;
        case (state)
            GET_A: begin
                if (do_rd) state_nxt = is_digit ? GET_OP : GET_A;
            end
            GET_OP: begin
                if (do_rd) state_nxt = op_valid ? GET_B : GET_A;
            end
            GET_B: begin
                if (do_rd) state_nxt = is_digit ? GET_END : GET_A;
            end
            GET_END: begin
                if (do_rd) state_nxt = (ch_in == CHAR_CR) ? LOAD_A : GET_A;
            end
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = LOAD_OP;
            LOAD_OP: state_nxt = GET_A;
            default: state_nxt = GET_A;
        endcase
    end

    // Moore outputs: pop request in GET states, load bus in LOAD states.
    always_comb begin
        RD_FIFO  = 1'b0;
        data_out = 8'h00;
        SEL      = 3'b000;
        case (state)
            GET_A, GET_OP, GET_B, GET_END: RD_FIFO = !empty;
            LOAD_A: begin
                data_out = DATOA;
                SEL      = 3'b001;
            end
            LOAD_B: begin
                data_out = DATOB;
                SEL      = 3'b010;
            end
            LOAD_OP: begin
                data_out = OP;
                SEL      = 3'b100;
            end
            default: ;
        endcase
    end

    // Captured character and decoded fields; rejected characters leave the
    // decoded fields untouched.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            CH    <= 8'h00;
            DATOA <= 8'h00;
            DATOB <= 8'h00;
            OP    <= 8'h00;
        end else if (do_rd) begin
            CH <= ch_in;
            case (state)
                GET_A:   if (is_digit) DATOA <= ch_in - CHAR_ZERO;
                GET_OP:  if (op_valid) OP <= op_code;
                GET_B:   if (is_digit) DATOB <= ch_in - CHAR_ZERO;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // ALU handler
    // ------------------------------------------------------------------
    logic [7:0] reg_a;
    logic [7:0] reg_b;
    logic [7:0] reg_op;

    // Operand/opcode registers loaded from the one-hot load bus.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            reg_a  <= 8'h00;
            reg_b  <= 8'h00;
            reg_op <= 8'h00;
        end else begin
            if (SEL[0]) reg_a  <= data_out;
            if (SEL[1]) reg_b  <= data_out;
            if (SEL[2]) reg_op <= data_out;
        end
    end

    // Result; two's-complement add/sub wrap the same as unsigned, so only the
    // arithmetic shift needs the signed view of A.
    always_comb begin
        RESULTADO = 8'h00;
        case (reg_op)
            OPC_ADD: RESULTADO = reg_a + reg_b;
            OPC_SUB: RESULTADO = reg_a - reg_b;
            OPC_AND: RESULTADO = reg_a & reg_b;
            OPC_OR:  RESULTADO = reg_a | reg_b;
            OPC_XOR: RESULTADO = reg_a ^ reg_b;
            OPC_NOR: RESULTADO = ~(reg_a | reg_b);
            OPC_SRA: RESULTADO = 8'($signed(reg_a) >>> reg_b);
            OPC_SRL: RESULTADO = reg_a >> reg_b;
            default: RESULTADO = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_int_rx_alu.sv
// Self-checking bench for int_rx_alu: a reference parser fed with every
// written character pushes expected loads/results to a scoreboard, and a
// monitor compares them when the load bus fires.
module tb_int_rx_alu;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       wr;
    logic [7:0] w_data;
    logic       full;
    logic       empty;
    logic [7:0] RESULTADO;
    logic [7:0] data_out;
    logic [2:0] SEL;
    logic       RD_FIFO;
    logic [2:0] STATE;
    logic [7:0] CH;
    logic [7:0] DATOA;
    logic [7:0] DATOB;
    logic [7:0] OP;

    int total = 0;
    int bad   = 0;

    int_rx_alu #(.B(8), .W(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .wr        (wr),
        .w_data    (w_data),
        .full      (full),
        .empty     (empty),
        .RESULTADO (RESULTADO),
        .data_out  (data_out),
        .SEL       (SEL),
        .RD_FIFO   (RD_FIFO),
        .STATE     (STATE),
        .CH        (CH),
        .DATOA     (DATOA),
        .DATOB     (DATOB),
        .OP        (OP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
    } exp_t;

    exp_t       sb_q[$];
    int         m_st;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [7:0] m_op;

    function automatic logic [7:0] op_of(input logic [7:0] c);
        case (c)
            "+":     return 8'h20;
            "-":     return 8'h22;
            "&":     return 8'h24;
            "|":     return 8'h25;
            "^":     return 8'h26;
            "~":     return 8'h27;
            ">":     return 8'h03;
            "}":     return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            8'h20:   return a + b;
            8'h22:   return a - b;
            8'h24:   return a & b;
            8'h25:   return a | b;
            8'h26:   return a ^ b;
            8'h27:   return ~(a | b);
            8'h03:   return 8'(sa >>> b);
            8'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic is_dig(input logic [7:0] c);
        return (c >= "0") && (c <= "9");
    endfunction

    task automatic model_reset();
        m_st = 0;
        m_a  = 8'h00;
        m_b  = 8'h00;
        m_op = 8'h00;
    endtask

    task automatic model_feed(input logic [7:0] c);
        exp_t e;
        case (m_st)
            0: if (is_dig(c)) begin m_a = c - 8'h30; m_st = 1; end
            1: if (op_of(c) != 8'h00) begin m_op = op_of(c); m_st = 2; end else m_st = 0;
            2: if (is_dig(c)) begin m_b = c - 8'h30; m_st = 3; end else m_st = 0;
            default: begin
                if (c == 8'h0D) begin
                    e.a   = m_a;
                    e.b   = m_b;
                    e.op  = m_op;
                    e.res = alu_ref(m_a, m_b, m_op);
                    sb_q.push_back(e);
                end
                m_st = 0;
            end
        endcase
    endtask

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        wr     = 1'b1;
        w_data = c;
        model_feed(c);
        @(posedge CLK);
        #1;
        wr     = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
        end
    endtask

    task automatic send_expr(input string s);
        send_str(s);
        send(8'h0D);
    endtask

    // ---------------- load-bus monitor / scoreboard compare ----------------
    logic [2:0] prev_sel = 3'b000;
    logic       pend     = 1'b0;
    int         sel_pulses = 0;

    always @(negedge CLK) begin
        if (pend) begin
            check("result", RESULTADO, sb_q[0].res);
            check("state_after_load", 8'(STATE), 8'h00);
            void'(sb_q.pop_front());
            pend = 1'b0;
        end
        if (SEL != 3'b000) begin
            sel_pulses++;
            if (sb_q.size() == 0) begin
                check("sel_unexpected", 8'(SEL), 8'h00);
            end else begin
                case (SEL)
                    3'b001: check("load_a", data_out, sb_q[0].a);
                    3'b010: begin
                        check("order_b", 8'(prev_sel), 8'h01);
                        check("load_b", data_out, sb_q[0].b);
                    end
                    3'b100: begin
                        check("order_op", 8'(prev_sel), 8'h02);
                        check("load_op", data_out, sb_q[0].op);
                        pend = 1'b1;
                    end
                    default: check("sel_onehot", 8'(SEL), 8'h00);
                endcase
            end
        end
        prev_sel = SEL;
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && (sb_q.size() != 0 || pend); i++) begin
            @(posedge CLK);
        end
        #1;
        check(tag, 8'(sb_q.size()), 8'h00);
    endtask

    // ---------------- main sequence ----------------
    int sel_before;

    initial begin
        RESET  = 1'b1;
        wr     = 1'b0;
        w_data = 8'h00;
        model_reset();
        idle(3);
        RESET  = 1'b0;

        // Reset state.
        check("rst_empty", 8'(empty), 8'h01);
        check("rst_full", 8'(full), 8'h00);
        check("rst_state", 8'(STATE), 8'h00);
        check("rst_result", RESULTADO, 8'h00);
        check("rst_datoa", DATOA, 8'h00);
        check("rst_ch", CH, 8'h00);
        check("rst_sel", 8'(SEL), 8'h00);
        check("rst_rd", 8'(RD_FIFO), 8'h00);
        idle(4);
        check("idle_empty", 8'(empty), 8'h01);

        // "7+3\r" spaced, with exact load latency.
        send(8'h37); idle(6);
        send(8'h2B); idle(6);
        send(8'h33); idle(6);
        check("pre_cr_state", 8'(STATE), 8'h03);
        send(8'h0D);
        idle(3);
        check("lat_before_op", RESULTADO, 8'h00);
        idle(1);
        check("lat_at_op", RESULTADO, 8'h0A);
        check("datoa_7", DATOA, 8'h07);
        check("op_add", OP, 8'h20);
        check("datob_3", DATOB, 8'h03);
        check("ch_cr", CH, 8'h0D);
        drain("drain_add");

        // Back-to-back expressions, second one negative.
        send_expr("9-5");
        send_expr("2-5");
        drain("drain_sub");
        check("sub_neg", RESULTADO, 8'hFD);

        // Remaining operators, back to back.
        send_expr("8>1");
        send_expr("9}1");
        send_expr("5^3");
        send_expr("5|2");
        send_expr("4&6");
        send_expr("4~6");
        drain("drain_ops");
        check("nor_final", RESULTADO, 8'hF9);
        check("ops_empty", 8'(empty), 8'h01);
        check("ops_full", 8'(full), 8'h00);

        // Invalid characters: consumed, no load, result held.
        sel_before = sel_pulses;
        send_str("x7+3A");
        idle(10);
        check("inv_state", 8'(STATE), 8'h00);
        check("inv_nosel", 8'(sel_pulses - sel_before), 8'h00);
        check("inv_result", RESULTADO, 8'hF9);
        check("inv_ch", CH, 8'h41);
        check("inv_datoa", DATOA, 8'h07);
        check("inv_datob", DATOB, 8'h03);
        check("inv_op", OP, 8'h20);
        check("inv_empty", 8'(empty), 8'h01);

        // Reset mid-expression.
        send(8'h37); idle(2);
        send(8'h2B); idle(2);
        check("mid_state", 8'(STATE), 8'h02);
        RESET = 1'b1;
        model_reset();
        idle(2);
        RESET = 1'b0;
        check("mrst_state", 8'(STATE), 8'h00);
        check("mrst_datoa", DATOA, 8'h00);
        check("mrst_op", OP, 8'h00);
        check("mrst_result", RESULTADO, 8'h00);
        check("mrst_empty", 8'(empty), 8'h01);
        sel_before = sel_pulses;
        send(8'h33); idle(2);
        check("post_a_state", 8'(STATE), 8'h01);
        check("post_a_datoa", DATOA, 8'h03);
        send(8'h0D); idle(6);
        check("post_nosel", 8'(sel_pulses - sel_before), 8'h00);
        check("post_result", RESULTADO, 8'h00);
        check("post_datob", DATOB, 8'h00);
        drain("drain_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
